// File: rtl/bus_arbiter_rx.sv
// Round-robin owner and receiver of a shared tristate bus.
// Grants one driver at a time through a one-hot enable, samples the bus
// at the end of the grant, and then holds every enable low for a fixed
// number of turnaround cycles. This gap keeps two drivers from ever
// overlapping on the wire.
module bus_arbiter_rx #(
    parameter int N_MASTERS    = 4,
    parameter int WIDTH        = 16,
    parameter int GRANT_CYCLES = 1,
    parameter int TURNAROUND   = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_MASTERS-1:0]         req,
    output logic [N_MASTERS-1:0]         en,
    input  logic [WIDTH-1:0]             bus,
    output logic [WIDTH-1:0]             data_out,
    output logic [$clog2(N_MASTERS)-1:0] src_id,
    output logic                         valid,
    output logic [N_MASTERS-1:0]         ack
);

    localparam int ID_W    = $clog2(N_MASTERS);
    localparam int CNT_MAX = (GRANT_CYCLES > TURNAROUND) ? GRANT_CYCLES : TURNAROUND;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t                 state_r, state_s;
    logic [CNT_W-1:0]       cnt_r, cnt_s;
    logic [ID_W-1:0]        last_r, last_s;   // most recent winner; also the active grantee
    logic [ID_W-1:0]        pick_s;
    logic [N_MASTERS-1:0]   en_s, ack_s;
    logic [WIDTH-1:0]       data_s;
    logic [ID_W-1:0]        src_s;
    logic                   valid_s;

    // Convert a master index into its one-hot enable pattern.
    function automatic logic [N_MASTERS-1:0] onehot(input logic [ID_W-1:0] idx);
        logic [N_MASTERS-1:0] v;
        v      = {N_MASTERS{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // Find the first requester strictly after 'last', wrapping around.
    // When nothing is requested, 'last' is returned unchanged.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_MASTERS-1:0] r,
                                                input logic [ID_W-1:0]      last);
        logic [ID_W-1:0] w;
        logic            found;
        int              idx;
        w     = last;
        found = 1'b0;
        for (int i = 1; i <= N_MASTERS; i++) begin
            idx = int'(last) + i;
            if (idx >= N_MASTERS) begin
                idx = idx - N_MASTERS;
            end else begin
                idx = idx;
            end
            if (!found && r[idx]) begin
                found = 1'b1;
                w     = ID_W'(idx);
            end else begin
                found = found;
            end
        end
        return w;
    endfunction

    assign pick_s = rr_pick(req, last_r);

    // Next-state and next-output logic for the IDLE / GRANT / TURN sequence.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        last_s  = last_r;
        en_s    = en;
        data_s  = data_out;
        src_s   = src_id;
        valid_s = 1'b0;
        ack_s   = {N_MASTERS{1'b0}};
        case (state_r)
            IDLE: begin
                if (|req) begin
                    last_s  = pick_s;
                    en_s    = onehot(pick_s);
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = GRANT;
                end else begin
                    en_s    = {N_MASTERS{1'b0}};
                end
            end
            GRANT: begin
                // The grantee's request is not consulted; a started grant always completes.
                if (cnt_r == CNT_W'(GRANT_CYCLES - 1)) begin
                    data_s  = bus;
                    src_s   = last_r;
                    valid_s = 1'b1;
                    ack_s   = onehot(last_r);
                    en_s    = {N_MASTERS{1'b0}};
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = TURN;
                end else begin
                    cnt_s   = cnt_r + CNT_W'(1);
                end
            end
            TURN: begin
                en_s = {N_MASTERS{1'b0}};
                if (cnt_r == CNT_W'(TURNAROUND - 1)) begin
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = IDLE;
                end else begin
                    cnt_s   = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                en_s    = {N_MASTERS{1'b0}};
                cnt_s   = {CNT_W{1'b0}};
                state_s = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset releases the bus immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            last_r   <= ID_W'(N_MASTERS - 1);
            en       <= {N_MASTERS{1'b0}};
            data_out <= {WIDTH{1'b0}};
            src_id   <= {ID_W{1'b0}};
            valid    <= 1'b0;
            ack      <= {N_MASTERS{1'b0}};
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            last_r   <= last_s;
            en       <= en_s;
            data_out <= data_s;
            src_id   <= src_s;
            valid    <= valid_s;
            ack      <= ack_s;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rx.sv
// Directed bench for bus_arbiter_rx: reset, single grant, rotation, wrap,
// random overlap check, and a second instance with longer grant/turnaround.
module tb_bus_arbiter_rx;

    localparam int N  = 4;
    localparam int W  = 16;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req, req2;
    logic [N-1:0]  en, en2, ack, ack2;
    logic [W-1:0]  bus, bus2, data_out, data_out2;
    logic [1:0]    src_id, src_id2;
    logic          valid, valid2;
    logic [W-1:0]  drv [N];

    int checks = 0;
    int errors = 0;

    bus_arbiter_rx #(.N_MASTERS(N), .WIDTH(W), .GRANT_CYCLES(1), .TURNAROUND(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .en(en), .bus(bus),
        .data_out(data_out), .src_id(src_id), .valid(valid), .ack(ack)
    );

    bus_arbiter_rx #(.N_MASTERS(N), .WIDTH(W), .GRANT_CYCLES(3), .TURNAROUND(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req(req2), .en(en2), .bus(bus2),
        .data_out(data_out2), .src_id(src_id2), .valid(valid2), .ack(ack2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tristate bus model: the enabled driver puts its word on the wire, else Z.
    always_comb begin
        bus = {W{1'bz}};
        for (int i = 0; i < N; i++) if (en[i]) bus = drv[i];
    end

    // Same bus model for the second instance.
    always_comb begin
        bus2 = {W{1'bz}};
        for (int i = 0; i < N; i++) if (en2[i]) bus2 = drv[i];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full grant on u_dut from IDLE: EN, capture, then turnaround end.
    task automatic serve(input logic [N-1:0] r, input int id, input bit drop);
        logic [N-1:0] oh;
        oh     = 4'b0000;
        oh[id] = 1'b1;
        req = r;
        step();
        check("grant_en", en, oh);
        check("grant_novalid", valid, 1'b0);
        if (drop) req = 4'b0000;
        step();
        check("cap_valid", valid, 1'b1);
        check("cap_ack", ack, oh);
        check("cap_src", src_id, id[1:0]);
        check("cap_data", data_out, drv[id]);
        check("cap_en_off", en, 4'b0000);
        step();
        check("turn_valid", valid, 1'b0);
        check("turn_ack", ack, 4'b0000);
        check("turn_en", en, 4'b0000);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] prev_en;
        int           zero_run;
        bit           seen;

        rst_n = 1'b0;
        req   = 4'b0000;
        req2  = 4'b0000;
        for (int i = 0; i < N; i++) drv[i] = 16'(i);
        step();
        step();
        check("rst_en", en, 4'b0000);
        check("rst_valid", valid, 1'b0);
        check("rst_ack", ack, 4'b0000);
        check("rst_data", data_out, 16'h0000);
        check("rst_src", src_id, 2'd0);
        check("rst_en2", en2, 4'b0000);
        rst_n = 1'b1;

        // Reset during a grant: EN drops without a clock edge, no capture follows.
        req = 4'b0100;
        step();
        check("midgrant_en", en, 4'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_en_drop", en, 4'b0000);
        req = 4'b0000;
        step();
        check("abort_valid", valid, 1'b0);
        check("abort_ack", ack, 4'b0000);
        check("abort_data", data_out, 16'h0000);
        check("abort_src", src_id, 2'd0);
        rst_n = 1'b1;
        step();

        // Single request; the requester drops REQ during GRANT.
        drv[1] = 16'hBEEF;
        serve(4'b0010, 1, 1'b1);
        check("hold_data", data_out, 16'hBEEF);
        drv[1] = 16'h0001;

        // Fresh reset so master 0 has first priority again.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // Fairness with all requesting, then wrap cases with REQ=1001.
        serve(4'b1111, 0, 1'b0);
        serve(4'b1111, 1, 1'b0);
        serve(4'b1111, 2, 1'b0);
        serve(4'b1111, 3, 1'b0);
        serve(4'b1001, 0, 1'b0);
        serve(4'b1001, 3, 1'b0);
        serve(4'b1001, 0, 1'b0);

        // Random requests: EN stays one-hot/zero and grants are separated.
        prev_en  = 4'b0000;
        zero_run = 0;
        seen     = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            req = 4'($urandom_range(0, 15));
            step();
            check("onehot0", 32'($onehot0(en)), 32'd1);
            if (en != 4'b0000) begin
                if (prev_en == 4'b0000 && seen) check("gap", 32'(zero_run >= 2), 32'd1);
                if (prev_en != 4'b0000) check("no_switch", en, prev_en);
                check("bus_known", 32'($isunknown(bus)), 32'd0);
                seen     = 1'b1;
                zero_run = 0;
            end else begin
                zero_run++;
            end
            prev_en = en;
        end
        req = 4'b0000;
        repeat (4) step();

        // Long grant / long turnaround instance.
        for (int i = 0; i < N; i++) drv[i] = 16'hC0D0 + 16'(i);
        req2 = 4'b0101;
        step();
        check("p_en_c1", en2, 4'b0001);
        step();
        check("p_en_c2", en2, 4'b0001);
        step();
        check("p_en_c3", en2, 4'b0001);
        check("p_novalid", valid2, 1'b0);
        step();
        check("p_valid", valid2, 1'b1);
        check("p_src", src_id2, 2'd0);
        check("p_data", data_out2, 16'hC0D0);
        check("p_ack", ack2, 4'b0001);
        check("p_turn1_en", en2, 4'b0000);
        step();
        check("p_turn2_en", en2, 4'b0000);
        check("p_valid_off", valid2, 1'b0);
        step();
        check("p_idle_en", en2, 4'b0000);
        step();
        check("p_next_en", en2, 4'b0100);
        req2 = 4'b0000;
        repeat (6) step();
        check("p_data2", data_out2, 16'hC0D2);
        check("p_src2", src_id2, 2'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
